// File: rtl/sram_boot_loader_pkg.sv
// Shared constants for the SRAM boot loader: FSM encoding, SRAM select
// values, full-word lane mask and a byte-lane insertion helper.
package sram_boot_pkg;

  localparam int unsigned ST_W = 3;

  // Legacy-compatible state constants
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_CLEAR = 3'd1;
  localparam logic [ST_W-1:0] ST_LOAD  = 3'd2;
  localparam logic [ST_W-1:0] ST_FLUSH = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

  localparam logic MEM_SEL_ISRAM = 1'b0;
  localparam logic MEM_SEL_DSRAM = 1'b1;

  localparam logic [3:0] WE_ALL = 4'hF;

  // Drop a byte into its big-endian lane: index 0 -> [31:24] ... 3 -> [7:0]
  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0: r[31:24] = b;
      2'd1: r[23:16] = b;
      2'd2: r[15:8]  = b;
      default: r[7:0] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sram_boot_loader_if.sv
// Byte-stream + SPRAM write-port bundle for the boot loader.
//   s_valid/s_data/s_last/s_ready : byte source handshake (bridge -> loader)
//   mem_cs/mem_sel/mem_we/mem_addr/mem_wdata : shared SRAM write port
// master = loader side, slave = bridge/SRAM side.
interface sram_boot_if #(
  parameter int unsigned AW = 14
) ();

  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_ready;

  logic          mem_cs;
  logic          mem_sel;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  modport master (
    input  s_valid, s_data, s_last,
    output s_ready, mem_cs, mem_sel, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output s_valid, s_data, s_last,
    input  s_ready, mem_cs, mem_sel, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/sram_boot_packer.sv
// Byte-to-word packer. Collects big-endian bytes into a 32-bit word.
//   hclk, hrst_b : clock, async active-low reset
//   clr          : restart packing from byte 0 with an empty word
//   accept       : byte handshake this cycle
//   byte_in      : accepted byte
//   last         : accepted byte ends the image
//   full_c       : this handshake completes a word (word-ready pulse)
//   word_c       : word including the byte being accepted; unfilled lanes 0
module sram_boot_packer
  import sram_boot_pkg::*;
(
  input  logic        hclk,
  input  logic        hrst_b,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  input  logic        last,
  output logic        full_c,
  output logic [31:0] word_c
);

  logic [1:0]  idx;
  logic [31:0] sr;

  // Combinational view lets the write strobe follow the 4th byte by one cycle
  always_comb begin
    word_c = put_byte(sr, idx, byte_in);
    full_c = accept & (idx == 2'd3);
  end

  // A completed or terminated word leaves the packer empty for the next one
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      idx <= 2'd0;
      sr  <= 32'd0;
    end else if (clr) begin
      idx <= 2'd0;
      sr  <= 32'd0;
    end else if (accept) begin
      if (full_c || last) begin
        idx <= 2'd0;
        sr  <= 32'd0;
      end else begin
        idx <= idx + 2'd1;
        sr  <= word_c;
      end
    end
  end

endmodule

// File: rtl/sram_boot_loader.sv
// Boot-image loader: zero-fills the data SRAM, streams a byte image into the
// instruction SRAM as 32-bit words, then releases the CPU core reset.
//   hclk, hrst_b : clock, async active-low reset
//   start        : one-cycle pulse, starts a boot sequence from IDLE
//   bus          : byte stream in + SRAM write port out
//   cpu_rst_b    : CPU core reset, released one cycle after DONE entry
//   busy         : CLEAR / LOAD / FLUSH
//   done         : DONE
//   ovf          : sticky, image larger than the instruction SRAM
module sram_boot_loader
  import sram_boot_pkg::*;
#(
  parameter int unsigned AW        = 14,
  parameter int unsigned CLR_WORDS = 16384
) (
  input  logic        hclk,
  input  logic        hrst_b,
  input  logic        start,
  sram_boot_if.master bus,
  output logic        cpu_rst_b,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  // One extra bit so the counter can reach 2**AW without wrapping
  localparam int unsigned CW = AW + 1;

  logic [ST_W-1:0] state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic            s_ready_q, s_ready_nxt;
  logic            mem_cs_q, mem_cs_nxt;
  logic            mem_sel_q, mem_sel_nxt;
  logic [3:0]      mem_we_q, mem_we_nxt;
  logic [AW-1:0]   mem_addr_q, mem_addr_nxt;
  logic [31:0]     mem_wdata_q, mem_wdata_nxt;
  logic            busy_nxt, done_nxt, ovf_nxt;

  logic            accept_c;
  logic            pk_clr_c;
  logic            full_c;
  logic [31:0]     word_c;

  assign accept_c = bus.s_valid & s_ready_q;

  sram_boot_packer u_packer (
    .hclk    (hclk),
    .hrst_b  (hrst_b),
    .clr     (pk_clr_c),
    .accept  (accept_c),
    .byte_in (bus.s_data),
    .last    (bus.s_last),
    .full_c  (full_c),
    .word_c  (word_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    s_ready_nxt   = 1'b0;
    mem_cs_nxt    = 1'b0;
    mem_sel_nxt   = mem_sel_q;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    ovf_nxt       = ovf;
    pk_clr_c      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          // First clear write is issued together with the CLEAR entry
          state_nxt     = ST_CLEAR;
          pk_clr_c      = 1'b1;
          ovf_nxt       = 1'b0;
          cnt_nxt       = CW'(1);
          mem_cs_nxt    = 1'b1;
          mem_sel_nxt   = MEM_SEL_DSRAM;
          mem_addr_nxt  = '0;
          mem_wdata_nxt = 32'd0;
        end
      end

      ST_CLEAR: begin
        if (cnt == CW'(CLR_WORDS)) begin
          state_nxt   = ST_LOAD;
          cnt_nxt     = '0;
          s_ready_nxt = 1'b1;
        end else begin
          mem_cs_nxt    = 1'b1;
          mem_sel_nxt   = MEM_SEL_DSRAM;
          mem_addr_nxt  = cnt[AW-1:0];
          mem_wdata_nxt = 32'd0;
          cnt_nxt       = cnt + CW'(1);
        end
      end

      ST_LOAD: begin
        s_ready_nxt = 1'b1;
        if (accept_c && (full_c || bus.s_last)) begin
          // Writes past the top of the SRAM are dropped, counter saturates
          if (cnt[AW]) begin
            ovf_nxt = 1'b1;
          end else begin
            mem_cs_nxt    = 1'b1;
            mem_sel_nxt   = MEM_SEL_ISRAM;
            mem_addr_nxt  = cnt[AW-1:0];
            mem_wdata_nxt = word_c;
            cnt_nxt       = cnt + CW'(1);
          end
        end
        // FLUSH is the cycle that carries the final write, aligned or not
        if (accept_c && bus.s_last) begin
          state_nxt   = ST_FLUSH;
          s_ready_nxt = 1'b0;
        end
      end

      ST_FLUSH: state_nxt = ST_DONE;

      ST_DONE: state_nxt = ST_DONE;

      default: state_nxt = ST_IDLE;
    endcase

    mem_we_nxt = mem_cs_nxt ? WE_ALL : 4'h0;
    busy_nxt   = (state_nxt == ST_CLEAR) || (state_nxt == ST_LOAD) ||
                 (state_nxt == ST_FLUSH);
    done_nxt   = (state_nxt == ST_DONE);
  end

  // State and registered outputs
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      s_ready_q   <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_we_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      cpu_rst_b   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      s_ready_q   <= s_ready_nxt;
      mem_cs_q    <= mem_cs_nxt;
      mem_sel_q   <= mem_sel_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      ovf         <= ovf_nxt;
      // Core reset lifts one cycle after done
      cpu_rst_b   <= done;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_boot_loader.sv
// Directed bench for sram_boot_loader: one instance with a short clear
// (AW=14, CLR_WORDS=8) and one tiny instance (AW=2, CLR_WORDS=4) for overflow.
module tb_sram_boot_loader;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic rst_a, rst_b, start_a, start_b;
  logic s_valid, s_last;
  logic [7:0] s_data;
  logic use_b;

  logic cpu_rst_b_a, busy_a, done_a, ovf_a;
  logic cpu_rst_b_b, busy_b, done_b, ovf_b;

  sram_boot_if #(.AW(14)) bus_a ();
  sram_boot_if #(.AW(2))  bus_b ();

  assign bus_a.s_valid = s_valid;
  assign bus_a.s_data  = s_data;
  assign bus_a.s_last  = s_last;
  assign bus_b.s_valid = s_valid;
  assign bus_b.s_data  = s_data;
  assign bus_b.s_last  = s_last;

  sram_boot_loader #(.AW(14), .CLR_WORDS(8)) dut_a (
    .hclk(hclk), .hrst_b(rst_a), .start(start_a), .bus(bus_a),
    .cpu_rst_b(cpu_rst_b_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
  );

  sram_boot_loader #(.AW(2), .CLR_WORDS(4)) dut_b (
    .hclk(hclk), .hrst_b(rst_b), .start(start_b), .bus(bus_b),
    .cpu_rst_b(cpu_rst_b_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
  );

  // Observed view of whichever instance is under test
  logic        m_cs, m_sel, m_ready, m_done, m_cpu, m_ovf, m_busy;
  logic [3:0]  m_we;
  logic [13:0] m_addr;
  logic [31:0] m_wdata;
  assign m_cs    = use_b ? bus_b.mem_cs    : bus_a.mem_cs;
  assign m_sel   = use_b ? bus_b.mem_sel   : bus_a.mem_sel;
  assign m_we    = use_b ? bus_b.mem_we    : bus_a.mem_we;
  assign m_addr  = use_b ? 14'(bus_b.mem_addr) : bus_a.mem_addr;
  assign m_wdata = use_b ? bus_b.mem_wdata : bus_a.mem_wdata;
  assign m_ready = use_b ? bus_b.s_ready   : bus_a.s_ready;
  assign m_done  = use_b ? done_b  : done_a;
  assign m_cpu   = use_b ? cpu_rst_b_b : cpu_rst_b_a;
  assign m_ovf   = use_b ? ovf_b  : ovf_a;
  assign m_busy  = use_b ? busy_b : busy_a;

  typedef struct {
    logic        sel;
    logic [13:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
    int          cyc;
  } wr_t;

  wr_t        wq[$];
  int         acc_q[$];
  logic [7:0] stim_q[$];
  int         cyc = 0;
  int         clr_rdy_hits = 0;
  int         total = 0;
  int         bad = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  // Sample mid-cycle: every write strobe and every byte handshake
  always @(negedge hclk) begin
    if (m_cs) begin
      wq.push_back('{sel: m_sel, addr: m_addr, data: m_wdata, we: m_we, cyc: cyc});
      if (m_sel && m_ready) clr_rdy_hits = clr_rdy_hits + 1;
    end
    if (s_valid && m_ready) acc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge hclk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge hclk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge hclk);
    while (!m_ready && n < 500) begin
      n = n + 1;
      @(negedge hclk);
    end
    if (!m_ready) chk("ready_timeout", 32'(m_ready), 32'd1);
    @(posedge hclk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Sends stim_q with s_last on the final byte; gap inserts an idle cycle
  task automatic send(input bit gap);
    for (int i = 0; i < stim_q.size(); i++) begin
      push_byte(stim_q[i], i == stim_q.size() - 1);
      if (gap && i != stim_q.size() - 1) begin
        @(posedge hclk); #1;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge hclk);
    while (!m_done && n < 2000) begin
      n = n + 1;
      @(negedge hclk);
    end
    chk({tag, "_done"}, 32'(m_done), 32'd1);
    chk({tag, "_cpu_lag"}, 32'(m_cpu), 32'd0);
    @(negedge hclk);
    chk({tag, "_cpu_rst_b"}, 32'(m_cpu), 32'd1);
    chk({tag, "_busy"}, 32'(m_busy), 32'd0);
  endtask

  task automatic reboot();
    @(posedge hclk); #1;
    if (use_b) rst_b = 1'b0; else rst_a = 1'b0;
    @(posedge hclk); #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    wq.delete();
    acc_q.delete();
    clr_rdy_hits = 0;
    pulse_start();
  endtask

  task automatic check_clear(input string tag, input int n);
    chk({tag, "_clr_rdy"}, 32'(clr_rdy_hits), 32'd0);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_clr_sel"},  32'(wq[i].sel),  32'd1);
      chk({tag, "_clr_addr"}, 32'(wq[i].addr), 32'(i));
      chk({tag, "_clr_data"}, wq[i].data, 32'd0);
      chk({tag, "_clr_we"},   32'(wq[i].we),   32'hF);
      chk({tag, "_clr_cyc"},  32'(wq[i].cyc - wq[0].cyc), 32'(i));
    end
  endtask

  task automatic check_load(input string tag, input int base, input int idx,
                            input logic [31:0] data);
    chk({tag, "_ld_sel"},  32'(wq[base + idx].sel),  32'd0);
    chk({tag, "_ld_addr"}, 32'(wq[base + idx].addr), 32'(idx));
    chk({tag, "_ld_data"}, wq[base + idx].data, data);
    chk({tag, "_ld_we"},   32'(wq[base + idx].we),   32'hF);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; use_b = 1'b0;

    repeat (3) @(negedge hclk);
    chk("rst_s_ready",  32'(bus_a.s_ready),  32'd0);
    chk("rst_mem_cs",   32'(bus_a.mem_cs),   32'd0);
    chk("rst_mem_sel",  32'(bus_a.mem_sel),  32'd0);
    chk("rst_mem_we",   32'(bus_a.mem_we),   32'd0);
    chk("rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus_a.mem_wdata,    32'd0);
    chk("rst_flags", {28'd0, cpu_rst_b_a, busy_a, done_a, ovf_a}, 32'd0);
    chk("rst_flags_b", {28'd0, cpu_rst_b_b, busy_b, done_b, ovf_b}, 32'd0);

    // Clear + aligned image, source always valid
    reboot();
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send(1'b0);
    wait_done("aln");
    chk("aln_nwr", 32'(wq.size()), 32'd10);
    if (wq.size() == 10 && acc_q.size() == 8) begin
      check_clear("aln", 8);
      check_load("aln", 8, 0, 32'h11223344);
      check_load("aln", 8, 1, 32'h55667788);
      chk("aln_lat0", 32'(wq[8].cyc), 32'(acc_q[3] + 1));
      chk("aln_lat1", 32'(wq[9].cyc), 32'(acc_q[7] + 1));
      chk("aln_nobubble", 32'(acc_q[7] - acc_q[0]), 32'd7);
    end
    chk("aln_ovf", 32'(m_ovf), 32'd0);
    // start is ignored once DONE
    pulse_start();
    repeat (3) @(negedge hclk);
    chk("done_start_nwr", 32'(wq.size()), 32'd10);
    chk("done_start_done", 32'(m_done), 32'd1);

    // Partial tail goes through FLUSH
    reboot();
    stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send(1'b0);
    chk("tail_ready_drop", 32'(m_ready), 32'd0);
    wait_done("tail");
    chk("tail_nwr", 32'(wq.size()), 32'd10);
    if (wq.size() == 10 && acc_q.size() == 5) begin
      check_load("tail", 8, 0, 32'hAABBCCDD);
      check_load("tail", 8, 1, 32'hEE000000);
      chk("tail_lat", 32'(wq[9].cyc), 32'(acc_q[4] + 1));
    end

    // Same image with gaps between bytes
    reboot();
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send(1'b1);
    wait_done("gap");
    chk("gap_nwr", 32'(wq.size()), 32'd10);
    if (wq.size() == 10 && acc_q.size() == 8) begin
      check_load("gap", 8, 0, 32'h11223344);
      check_load("gap", 8, 1, 32'h55667788);
      chk("gap_lat1", 32'(wq[9].cyc), 32'(acc_q[7] + 1));
    end

    // Overflow on the 4-word instance: 5 words, last on byte 20
    use_b = 1'b1;
    reboot();
    stim_q.delete();
    for (int i = 1; i <= 20; i++) stim_q.push_back(8'(i));
    send(1'b0);
    wait_done("ovf");
    chk("ovf_nwr", 32'(wq.size()), 32'd8);
    if (wq.size() == 8) begin
      check_clear("ovf", 4);
      check_load("ovf", 4, 0, 32'h01020304);
      check_load("ovf", 4, 1, 32'h05060708);
      check_load("ovf", 4, 2, 32'h090A0B0C);
      check_load("ovf", 4, 3, 32'h0D0E0F10);
    end
    chk("ovf_flag", 32'(m_ovf), 32'd1);
    repeat (4) @(negedge hclk);
    chk("ovf_sticky", 32'(m_ovf), 32'd1);
    chk("ovf_done", 32'(m_done), 32'd1);

    // Reset in the middle of LOAD, then a fresh boot
    use_b = 1'b0;
    reboot();
    for (int i = 0; i < 6; i++) push_byte(8'h11 * 8'(i + 1), 1'b0);
    rst_a = 1'b0;
    #1;
    chk("mid_s_ready",  32'(bus_a.s_ready),  32'd0);
    chk("mid_mem_cs",   32'(bus_a.mem_cs),   32'd0);
    chk("mid_mem_wdata", bus_a.mem_wdata,    32'd0);
    chk("mid_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    chk("mid_flags", {28'd0, cpu_rst_b_a, busy_a, done_a, ovf_a}, 32'd0);
    @(posedge hclk); #1;
    rst_a = 1'b1;
    wq.delete();
    acc_q.delete();
    clr_rdy_hits = 0;
    pulse_start();
    stim_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(1'b0);
    wait_done("mid");
    chk("mid_nwr", 32'(wq.size()), 32'd9);
    if (wq.size() == 9) begin
      check_clear("mid", 8);
      check_load("mid", 8, 0, 32'hDEADBEEF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
